// File: rtl/cevero_dvfs_sequencer.sv
// Applies DVFS voltage/frequency targets to the regulator and clock generator in a safe order.
// Optional ack timeout: define CEVERO_DVFS_SEQ_TIMEOUT_EN.
module cevero_dvfs_sequencer #(
  parameter logic [2:0]  ResetVoltage = 3'd5,
  parameter logic [31:0] ResetFreq    = 32'd100,
  parameter logic [31:0] MinFreq      = 32'd10,
  parameter logic [31:0] MaxFreq      = 32'd100,
  parameter logic [2:0]  MaxVoltage   = 3'd5,
  parameter int unsigned SettleCycles = 4,
  parameter int unsigned AckTimeout   = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [2:0]  target_voltage_i,
  input  logic [31:0] target_freq_i,
  output logic        vreg_req_o,
  output logic [2:0]  vreg_level_o,
  input  logic        vreg_ack_i,
  output logic [31:0] freq_o,
  output logic [2:0]  voltage_o,
  output logic        busy_o,
  output logic        error_o,
  output logic [2:0]  dbg_state_o
);

  // Handshake: vreg_req_o rises on entry to VUP/VDN and holds vreg_level_o stable;
  // the first clock edge that samples vreg_ack_i high while req is up completes it.
  typedef enum logic [2:0] {
    IDLE, VUP, VUP_SETTLE, FDOWN, VDN, VDN_SETTLE, FSET
  } state_e;

  state_e      state_q, state_d;
  logic        phase_q, phase_d;
  logic [2:0]  voltage_q, voltage_d;
  logic [31:0] freq_q, freq_d;
  logic        req_q, req_d;
  logic [2:0]  level_q, level_d;
  logic [2:0]  tgt_v_q, tgt_v_d;
  logic [31:0] tgt_f_q, tgt_f_d;
  logic [31:0] settle_q, settle_d;
  logic [2:0]  clamp_v;
  logic [31:0] clamp_f;

`ifdef CEVERO_DVFS_SEQ_TIMEOUT_EN
  logic [31:0] to_q, to_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    clamp_f = target_freq_i;
    if (target_freq_i < MinFreq) clamp_f = MinFreq;
    else if (target_freq_i > MaxFreq) clamp_f = MaxFreq;
    clamp_v = (target_voltage_i > MaxVoltage) ? MaxVoltage : target_voltage_i;
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    voltage_d = voltage_q;
    freq_d    = freq_q;
    req_d     = req_q;
    level_d   = level_q;
    tgt_v_d   = tgt_v_q;
    tgt_f_d   = tgt_f_q;
    settle_d  = settle_q;
`ifdef CEVERO_DVFS_SEQ_TIMEOUT_EN
    to_d      = to_q;
    err_d     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (clamp_v != voltage_q || clamp_f != freq_q) begin
          tgt_v_d = clamp_v;
          tgt_f_d = clamp_f;
          phase_d = 1'b0;
          if (clamp_v > voltage_q) begin
            state_d = VUP;
            req_d   = 1'b1;
            level_d = clamp_v;
`ifdef CEVERO_DVFS_SEQ_TIMEOUT_EN
            to_d    = '0;
`endif
          end else if (clamp_v < voltage_q) begin
            state_d = FDOWN;
          end else begin
            state_d = FSET;
          end
        end
      end
      VUP, VDN: begin
        if (vreg_ack_i) begin
          voltage_d = tgt_v_q;
          req_d     = 1'b0;
          level_d   = tgt_v_q;
          settle_d  = 32'(SettleCycles);
          state_d   = (state_q == VUP) ? VUP_SETTLE : VDN_SETTLE;
`ifdef CEVERO_DVFS_SEQ_TIMEOUT_EN
          to_d      = '0;
        end else if (to_q == 32'(AckTimeout - 1)) begin
          // Abandon the change; the level reverts to the last confirmed voltage.
          req_d   = 1'b0;
          level_d = voltage_q;
          err_d   = 1'b1;
          to_d    = '0;
          state_d = IDLE;
        end else begin
          to_d    = to_q + 32'd1;
`endif
        end
      end
      VUP_SETTLE, VDN_SETTLE: begin
        if (settle_q <= 32'd1) begin
          settle_d = '0;
          phase_d  = 1'b0;
          state_d  = FSET;
        end else begin
          settle_d = settle_q - 32'd1;
        end
      end
      FDOWN: begin
        // A frequency that would rise is held until FSET, after the voltage drop.
        if (!phase_q) begin
          if (tgt_f_q <= freq_q) freq_d = tgt_f_q;
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          state_d = VDN;
          req_d   = 1'b1;
          level_d = tgt_v_q;
`ifdef CEVERO_DVFS_SEQ_TIMEOUT_EN
          to_d    = '0;
`endif
        end
      end
      FSET: begin
        if (!phase_q) begin
          freq_d  = tgt_f_q;
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = 1'b0;
        req_d   = 1'b0;
        level_d = voltage_q;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      phase_q   <= 1'b0;
      voltage_q <= ResetVoltage;
      freq_q    <= ResetFreq;
      req_q     <= 1'b0;
      level_q   <= ResetVoltage;
      tgt_v_q   <= ResetVoltage;
      tgt_f_q   <= ResetFreq;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      voltage_q <= voltage_d;
      freq_q    <= freq_d;
      req_q     <= req_d;
      level_q   <= level_d;
      tgt_v_q   <= tgt_v_d;
      tgt_f_q   <= tgt_f_d;
      settle_q  <= settle_d;
    end
  end

`ifdef CEVERO_DVFS_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end
  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

  assign vreg_req_o   = req_q;
  assign vreg_level_o = level_q;
  assign voltage_o    = voltage_q;
  assign freq_o       = freq_q;
  assign busy_o       = (state_q != IDLE);
  assign dbg_state_o  = state_q;

endmodule
